// File: rtl/instr_prefetch_queue_pkg.sv
// instr_prefetch_queue_pkg
//   Shared definitions for the instruction prefetch queue: instruction width,
//   default reset PC, fetch FSM state encoding, the queue entry payload and a
//   word-alignment helper.
//   Ports: none (package).
package instr_prefetch_queue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetchState_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pcPlus4;
    } queueEntry_t;

    localparam int unsigned ENTRY_W = $bits(queueEntry_t);

    // Force an address onto a word boundary.
    function automatic logic [INSTR_W-1:0] wordAlign(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// instr_fifo
//   Synchronous in-order FIFO holding fetched {instruction, PC+4} entries.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     push/pushData  write an entry (caller guarantees a free slot)
//     pop          remove the head (ignored when empty)
//     clear        empty the FIFO and rewind pointers; wins over push/pop
//     headData     current head entry
//     count        occupancy 0..DEPTH
//     notEmpty     registered head-valid flag
module instr_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         pushData,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     notEmpty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   countNext;
    logic             doPop;

    // Occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        doPop     = pop && notEmpty;
        countNext = count;
        if (clear) begin
            countNext = '0;
        end else if (push && !doPop) begin
            countNext = count + (PTR_W+1)'(1);
        end else if (!push && doPop) begin
            countNext = count - (PTR_W+1)'(1);
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            notEmpty <= 1'b0;
        end else begin
            count    <= countNext;
            notEmpty <= (countNext != '0);
            if (clear) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (push)  wrPtr <= wrPtr + PTR_W'(1);
                if (doPop) rdPtr <= rdPtr + PTR_W'(1);
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Fetches instructions from a multi-cycle instruction memory (req/ack),
//   buffers them in order and presents {instruction, PC+4} to decode.
//   Branch/jump redirects flush the queue and retarget fetch.
//   Optional macro PREFETCH_STATS_EN adds saturating fetchCount/flushCount.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     redirectValid/redirectPc taken branch/jump and its target
//     deqReady                 decode accepts the head this cycle
//     instrValid/instrOut/pcPlus4Out  queue head
//     imemReq/imemAddr         memory request (stable until ack)
//     imemAck/imemData         memory response (may be same cycle as req)
//     fetchCount/flushCount    statistics (PREFETCH_STATS_EN only)
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned        DEPTH    = 4,
    parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirectValid,
    input  logic [INSTR_W-1:0] redirectPc,
    input  logic               deqReady,
    output logic               instrValid,
    output logic [INSTR_W-1:0] instrOut,
    output logic [INSTR_W-1:0] pcPlus4Out,
    output logic               imemReq,
    output logic [INSTR_W-1:0] imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]        fetchCount,
    output logic [31:0]        flushCount
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetchState_t        state;
    logic [INSTR_W-1:0] fetchPc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   countNext;
    logic [INSTR_W-1:0] pcNext;
    queueEntry_t        pushEntry;
    queueEntry_t        headEntry;
    logic               enq;
    logic               deq;
    logic               holdReq;
    logic               issueReq;

    // Transfer bookkeeping and slot reservation. A new request is only issued
    // when the queue, after this cycle's enq/deq/flush, still has a free slot,
    // so the in-flight word always has somewhere to land.
    always_comb begin
        enq       = imemReq && imemAck && (state == WAIT) && !redirectValid;
        deq       = instrValid && deqReady && !redirectValid;
        holdReq   = imemReq && !imemAck;
        countNext = count;
        if (redirectValid) begin
            countNext = '0;
        end else if (enq && !deq) begin
            countNext = count + CNT_W'(1);
        end else if (!enq && deq) begin
            countNext = count - CNT_W'(1);
        end
        pcNext = fetchPc;
        if (redirectValid) begin
            pcNext = wordAlign(redirectPc);
        end else if (enq) begin
            pcNext = fetchPc + 32'd4;
        end
        issueReq          = !holdReq && (countNext < CNT_W'(DEPTH));
        pushEntry.instr   = imemData;
        pushEntry.pcPlus4 = fetchPc + 32'd4;
    end

    // Fetch FSM. While a request is held its address never changes; a redirect
    // that catches an unacked request marks it stale (DISCARD) instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            imemReq  <= 1'b0;
            imemAddr <= wordAlign(RESET_PC);
            fetchPc  <= wordAlign(RESET_PC);
        end else begin
            fetchPc <= pcNext;
            if (holdReq) begin
                if (redirectValid && (state == WAIT)) state <= DISCARD;
            end else if (issueReq) begin
                imemReq  <= 1'b1;
                imemAddr <= pcNext;
                state    <= WAIT;
            end else begin
                imemReq <= 1'b0;
                state   <= FETCH;
            end
        end
    end

    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (enq),
        .pop      (deq),
        .clear    (redirectValid),
        .pushData (pushEntry),
        .headData (headEntry),
        .count    (count),
        .notEmpty (instrValid)
    );

    assign instrOut   = headEntry.instr;
    assign pcPlus4Out = headEntry.pcPlus4;

`ifdef PREFETCH_STATS_EN
    logic dropsWord;
    assign dropsWord = redirectValid && (instrValid || (imemReq && (state == WAIT)));

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCount <= '0;
            flushCount <= '0;
        end else begin
            if (enq && (fetchCount != '1))       fetchCount <= fetchCount + 32'd1;
            if (dropsWord && (flushCount != '1)) flushCount <= flushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
`timescale 1ns/1ps
module tb_instr_prefetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        deqReady;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] pcPlus4Out;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
`ifdef PREFETCH_STATS_EN
    logic [31:0] fetchCount;
    logic [31:0] flushCount;
    logic [31:0] fetch0;
    logic [31:0] flush0;
`endif

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    always #5 clk = ~clk;

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc),
        .deqReady      (deqReady),
        .instrValid    (instrValid),
        .instrOut      (instrOut),
        .pcPlus4Out    (pcPlus4Out),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemAck       (imemAck),
        .imemData      (imemData)
`ifdef PREFETCH_STATS_EN
        ,
        .fetchCount    (fetchCount),
        .flushCount    (flushCount)
`endif
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Memory responder: ack after reqDelay cycles of request (0 = same cycle).
    int waitCnt   = 0;
    int reqDelay  = 0;
    int delayMode = 0;
    assign imemAck  = imemReq && (waitCnt >= reqDelay);
    assign imemData = memWord(imemAddr);
    always @(posedge clk) begin
        if (imemReq && !imemAck) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt  <= 0;
            reqDelay <= (delayMode < 0) ? int'($urandom_range(0, 3)) : delayMode;
        end
    end

    // Reference: after reset or a redirect the consumer must see consecutive
    // words starting at the (aligned) target, nothing else.
    logic [31:0] expQ[$];
    task automatic loadExp(input logic [31:0] base);
        expQ.delete();
        for (int i = 0; i < 1200; i++) expQ.push_back(base + 32'(4 * i));
    endtask
    always @(posedge clk) begin
        if (rst)                loadExp(RESET_PC);
        else if (redirectValid) loadExp({redirectPc[31:2], 2'b00});
    end

    // Monitor: handshake stability, flush visibility and the in-order stream.
    logic        prevReq   = 1'b0;
    logic        prevAck   = 1'b0;
    logic        prevRst   = 1'b1;
    logic        prevRedir = 1'b0;
    logic [31:0] prevAddr  = 32'h0;
    always @(negedge clk) begin
        logic [31:0] p;
        if (!rst) begin
            if (prevReq && !prevAck && !prevRst) begin
                chk("req_hold", 32'(imemReq), 32'd1);
                chk("addr_hold", imemAddr, prevAddr);
            end
            if (prevRedir && !prevRst) chk("valid_after_redirect", 32'(instrValid), 32'd0);
            if (imemReq) chk("addr_align", 32'(imemAddr[1:0]), 32'd0);
            if (instrValid && deqReady && !redirectValid) begin
                if (expQ.size() == 0) begin
                    flag("scoreboard_empty");
                end else begin
                    p = expQ.pop_front();
                    chk("instr", instrOut, memWord(p));
                    chk("pcPlus4", pcPlus4Out, p + 32'd4);
                    pops++;
                end
            end
        end
        prevReq   <= imemReq;
        prevAck   <= imemAck;
        prevRst   <= rst;
        prevRedir <= redirectValid;
        prevAddr  <= imemAddr;
    end

    task automatic redirectTo(input logic [31:0] pc);
        @(posedge clk); #1;
        redirectValid = 1'b1;
        redirectPc    = pc;
        @(posedge clk); #1;
        redirectValid = 1'b0;
    endtask

    initial begin
        int n;
        int acks;
        int p0;
        rst = 1'b1; redirectValid = 1'b0; redirectPc = 32'h0; deqReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req", 32'(imemReq), 32'd0);
        chk("reset_valid", 32'(instrValid), 32'd0);
`ifdef PREFETCH_STATS_EN
        chk("reset_fetchCount", fetchCount, 32'd0);
        chk("reset_flushCount", flushCount, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0; deqReady = 1'b1;

        // Streaming from reset with same-cycle acks.
        n = 0;
        while (!instrValid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) flag("t1_first_valid");
        chk("t1_first_pc4", pcPlus4Out, 32'h4);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("t1_no_bubble", 32'(instrValid), 32'd1);
            chk("t1_pc4", pcPlus4Out, 32'(4 * (i + 1)));
        end

        // Stalled consumer: exactly DEPTH words fetched, then request stops.
        @(posedge clk); #1;
`ifdef PREFETCH_STATS_EN
        flush0 = flushCount;
`endif
        redirectValid = 1'b1; redirectPc = 32'h400; deqReady = 1'b0;
        @(posedge clk); #1;
        redirectValid = 1'b0;
`ifdef PREFETCH_STATS_EN
        fetch0 = fetchCount;
`endif
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imemReq && imemAck) acks++;
        end
        chk("t2_acks", 32'(acks), 32'd4);
        chk("t2_req_low", 32'(imemReq), 32'd0);
        chk("t2_valid", 32'(instrValid), 32'd1);
`ifdef PREFETCH_STATS_EN
        chk("t2_fetchCount", fetchCount - fetch0, 32'd4);
        chk("t2_flushCount", flushCount - flush0, 32'd1);
`endif
        @(posedge clk); #1;
        deqReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_drain_valid", 32'(instrValid), 32'd1);
            chk("t2_drain_pc4", pcPlus4Out, 32'h404 + 32'(4 * i));
        end

        // Redirect hits an outstanding slow request.
        delayMode = 3;
        redirectTo(32'h10);
        n = 0;
        while (!(imemReq && imemAddr == 32'h10 && waitCnt == 0) && n < 30) begin
            @(negedge clk); n++;
        end
        if (n >= 30) flag("t3_req10");
        @(posedge clk); #1;
`ifdef PREFETCH_STATS_EN
        fetch0 = fetchCount;
        flush0 = flushCount;
`endif
        redirectValid = 1'b1; redirectPc = 32'h100; deqReady = 1'b0;
        @(posedge clk); #1;
        redirectValid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(imemReq && imemAck) && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) flag("t3_stale_ack");
        chk("t3_stale_addr", imemAddr, 32'h10);
        @(negedge clk);
        chk("t3_next_req", 32'(imemReq), 32'd1);
        chk("t3_next_addr", imemAddr, 32'h100);
        n = 0;
        while (!(instrValid && !imemReq) && n < 60) begin @(negedge clk); n++; end
        if (n >= 60) flag("t3_fill");
        chk("t3_first_pc4", pcPlus4Out, 32'h104);
`ifdef PREFETCH_STATS_EN
        chk("t3_fetchCount", fetchCount - fetch0, 32'd4);
        chk("t3_flushCount", flushCount - flush0, 32'd1);
`endif
        @(posedge clk); #1;
        deqReady = 1'b1;

        // Redirect in the same cycle as an ack.
        delayMode = 0;
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        redirectValid = 1'b1; redirectPc = 32'h203;
        @(negedge clk);
        chk("t4_ack_same_cycle", 32'(imemReq && imemAck), 32'd1);
        @(posedge clk); #1;
        redirectValid = 1'b0;
        @(negedge clk);
        chk("t4_valid", 32'(instrValid), 32'd0);
        chk("t4_req", 32'(imemReq), 32'd1);
        chk("t4_addr", imemAddr, 32'h200);

        // Reset while waiting, with the ack landing in the reset cycle.
        delayMode = 1;
        n = 0;
        while (!(imemReq && !imemAck) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) flag("t5_wait");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ack_in_reset", 32'(imemReq && imemAck), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_req", 32'(imemReq), 32'd0);
        chk("t5_valid", 32'(instrValid), 32'd0);
        n = 0;
        while (!imemReq && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) flag("t5_restart");
        chk("t5_addr", imemAddr, RESET_PC);

        // Randomized traffic, including targets near the top of the address space.
        delayMode = -1;
        p0 = pops;
        redirectTo(32'hFFFF_FFF4);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            deqReady      = ($urandom_range(0, 9) < 7);
            redirectValid = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) redirectPc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           redirectPc = $urandom;
        end
        @(posedge clk); #1;
        redirectValid = 1'b0; deqReady = 1'b1;
        repeat (20) @(negedge clk);
        chk("liveness", 32'(pops - p0 > 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
